// File: rtl/s_mem_pkg.sv
// ---------------------------------------------------------------------------
// s_mem_pkg
// Shared types and constants for the RC4 S-memory phase sequencer.
//   state_t      : sequencer FSM states
//   PH_*         : values presented on the 2-bit phase output
//   DEF_ADDR_W / DEF_DATA_W : default S RAM geometry
//   phase_of()   : maps a state to its phase code
// ---------------------------------------------------------------------------
package s_mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_RUN,
    ST_KSA_GO,
    ST_KSA_RUN,
    ST_PRGA_GO,
    ST_PRGA_RUN,
    ST_FINISH,
    ST_FAULT
  } state_t;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      ST_INIT_GO, ST_INIT_RUN: phase_of = PH_INIT;
      ST_KSA_GO,  ST_KSA_RUN:  phase_of = PH_KSA;
      ST_PRGA_GO, ST_PRGA_RUN: phase_of = PH_PRGA;
      default:                 phase_of = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/s_mem_sequencer_watchdog.sv
// ---------------------------------------------------------------------------
// phase_watchdog
// Cycle counter bounding how long one client phase may run.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the count (asserted in every GO state)
//   enable       : count this cycle (asserted in every RUN state)
//   expired      : this is the TIMEOUT-th enabled cycle since the last clear
// The count is 0 in the first RUN cycle, so it reads TIMEOUT-1 exactly in
// the TIMEOUT-th RUN cycle; expired is gated by enable so it only matters
// while a phase is actually running.
// ---------------------------------------------------------------------------
module phase_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      // Saturate at LAST so the counter can never wrap back to zero.
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/s_mem_sequencer.sv
// ---------------------------------------------------------------------------
// s_mem_sequencer
// Phase controller for the RC4 decryption core: runs S-array init, KSA and
// PRGA in order, pulses each client's start, waits for its done, and gives
// the active client exclusive access to the single-port S RAM.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   start                         : request a full init->KSA->PRGA sequence
//   {init,ksa,prga}_start         : one-cycle start pulse per client
//   {init,ksa,prga}_done          : client completion (level or pulse)
//   {init,ksa,prga}_addr/data/wren: client RAM requests
//   s_addr, s_data, s_wren        : muxed S RAM port
//   phase                         : 0 none, 1 init, 2 KSA, 3 PRGA
//   busy / done / error           : in progress / completed / watchdog fault
// All outputs are a decode of the registered state (plus client inputs for
// the RAM mux), so an asynchronous reset silences them immediately.
// ---------------------------------------------------------------------------
module s_mem_sequencer
  import s_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              init_start,
  output logic              ksa_start,
  output logic              prga_start,
  input  logic              init_done,
  input  logic              ksa_done,
  input  logic              prga_done,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [DATA_W-1:0] ksa_data,
  input  logic [DATA_W-1:0] prga_data,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data,
  output logic              s_wren,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t state_reg, state_next;
  logic   wd_clear, wd_enable, wd_expired;

  phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    init_start = 1'b0;
    ksa_start  = 1'b0;
    prga_start = 1'b0;
    s_addr     = '0;
    s_data     = '0;
    s_wren     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    phase      = phase_of(state_reg);
    busy       = (phase_of(state_reg) != PH_NONE);

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_INIT_GO;
      end
      ST_FINISH: begin
        done = 1'b1;
        if (start) state_next = ST_INIT_GO;
      end
      ST_FAULT: begin
        error = 1'b1;
        if (start) state_next = ST_INIT_GO;
      end
      // GO states ignore any done still high from a previous request.
      ST_INIT_GO: begin
        init_start = 1'b1;
        wd_clear   = 1'b1;
        state_next = ST_INIT_RUN;
      end
      ST_KSA_GO: begin
        ksa_start  = 1'b1;
        wd_clear   = 1'b1;
        state_next = ST_KSA_RUN;
      end
      ST_PRGA_GO: begin
        prga_start = 1'b1;
        wd_clear   = 1'b1;
        state_next = ST_PRGA_RUN;
      end
      // In RUN states the client's done is checked before the watchdog, so
      // a done arriving in the last allowed cycle still advances normally.
      ST_INIT_RUN: begin
        wd_enable = 1'b1;
        s_addr    = init_addr;
        s_data    = init_data;
        s_wren    = init_wren;
        if (init_done)       state_next = ST_KSA_GO;
        else if (wd_expired) state_next = ST_FAULT;
      end
      ST_KSA_RUN: begin
        wd_enable = 1'b1;
        s_addr    = ksa_addr;
        s_data    = ksa_data;
        s_wren    = ksa_wren;
        if (ksa_done)        state_next = ST_PRGA_GO;
        else if (wd_expired) state_next = ST_FAULT;
      end
      ST_PRGA_RUN: begin
        wd_enable = 1'b1;
        s_addr    = prga_addr;
        s_data    = prga_data;
        s_wren    = prga_wren;
        if (prga_done)       state_next = ST_FINISH;
        else if (wd_expired) state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_s_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_s_mem_sequencer
// Two sequencers (TIMEOUT=4096 and TIMEOUT=16) share one set of client
// inputs. Directed table, hand-written corner sequences, then random
// stimulus against a phase-level reference model.
// ---------------------------------------------------------------------------
module tb_s_mem_sequencer;

  typedef struct packed {
    logic [2:0] st;     // {init_start, ksa_start, prga_start}
    logic [7:0] addr;
    logic [7:0] data;
    logic       wren;
    logic [1:0] phase;
    logic       busy;
    logic       done;
    logic       error;
  } obs_t;

  typedef struct {
    logic       start;
    logic [2:0] dn;     // {init_done, ksa_done, prga_done}
    obs_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0;
  logic [7:0] init_addr = 8'h11, ksa_addr = 8'h22, prga_addr = 8'h33;
  logic [7:0] init_data = 8'hA1, ksa_data = 8'hA2, prga_data = 8'hA3;
  logic       init_wren = 1'b1, ksa_wren = 1'b1, prga_wren = 1'b1;

  logic [2:0] st_a, st_b;
  logic [7:0] addr_a, addr_b, data_a, data_b;
  logic       wren_a, wren_b, busy_a, busy_b, done_a, done_b, error_a, error_b;
  logic [1:0] phase_a, phase_b;
  obs_t       obs_a, obs_b;

  assign obs_a = {st_a, addr_a, data_a, wren_a, phase_a, busy_a, done_a, error_a};
  assign obs_b = {st_b, addr_b, data_b, wren_b, phase_b, busy_b, done_b, error_b};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  s_mem_sequencer #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4096)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_start(st_a[2]), .ksa_start(st_a[1]), .prga_start(st_a[0]),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(addr_a), .s_data(data_a), .s_wren(wren_a),
    .phase(phase_a), .busy(busy_a), .done(done_a), .error(error_a)
  );

  s_mem_sequencer #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_start(st_b[2]), .ksa_start(st_b[1]), .prga_start(st_b[0]),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(addr_b), .s_data(data_b), .s_wren(wren_b),
    .phase(phase_b), .busy(busy_b), .done(done_b), .error(error_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [2:0] st, input logic [1:0] ph,
                              input logic [7:0] a, input logic [7:0] d, input logic w,
                              input logic b, input logic dn, input logic e);
    obs_t o;
    o.st = st; o.addr = a; o.data = d; o.wren = w;
    o.phase = ph; o.busy = b; o.done = dn; o.error = e;
    return o;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0; init_done = 1'b0; ksa_done = 1'b0; prga_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // From IDLE: start, one INIT_RUN cycle with init_done, through KSA_GO.
  // Returns just before the first KSA_RUN cycle.
  task automatic run_to_ksa_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); init_done = 1'b1;
    @(negedge clk); init_done = 1'b0;
  endtask

  // ---------------- reference model (per-phase bookkeeping) ----------------
  int m_ph [2];     // 0 none, 1..3 active phase
  bit m_go [2];     // first cycle of the active phase
  int m_run[2];     // RUN cycles already completed in this phase
  bit m_fin[2], m_flt[2];

  function automatic int to_of(input int i);
    return (i == 0) ? 4096 : 16;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_go[i] = 0; m_run[i] = 0; m_fin[i] = 0; m_flt[i] = 0;
    end
  endtask

  function automatic obs_t exp_obs(input int i);
    obs_t e = '0;
    if (m_ph[i] == 0) begin
      e.done  = m_fin[i];
      e.error = m_flt[i];
    end else begin
      e.phase = 2'(m_ph[i]);
      e.busy  = 1'b1;
      if (m_go[i]) e.st = 3'(4 >> (m_ph[i] - 1));
      else if (m_ph[i] == 1) begin e.addr = init_addr; e.data = init_data; e.wren = init_wren; end
      else if (m_ph[i] == 2) begin e.addr = ksa_addr;  e.data = ksa_data;  e.wren = ksa_wren;  end
      else                   begin e.addr = prga_addr; e.data = prga_data; e.wren = prga_wren; end
    end
    return e;
  endfunction

  task automatic m_step(input int i);
    logic d;
    if (m_ph[i] == 0) begin
      if (start) begin m_ph[i] = 1; m_go[i] = 1; m_fin[i] = 0; m_flt[i] = 0; end
    end else if (m_go[i]) begin
      m_go[i] = 0; m_run[i] = 0;
    end else begin
      d = (m_ph[i] == 1) ? init_done : (m_ph[i] == 2) ? ksa_done : prga_done;
      if (d) begin
        if (m_ph[i] == 3) begin m_ph[i] = 0; m_fin[i] = 1; end
        else begin m_ph[i]++; m_go[i] = 1; end
      end else if (m_run[i] + 1 == to_of(i)) begin
        m_ph[i] = 0; m_flt[i] = 1;
      end else begin
        m_run[i]++;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    vec_t tbl[14];
    int   c_i, c_k, c_p, first_done, seq_code, cnt;
    int   np[3];
    bit   err_seen, pulse_seen;
    logic [1:0] last_ph;

    // Clients hold distinct addr/data with wren=1 throughout the directed part.
    tbl[0]  = '{1'b0, 3'b000, mk(3'b000, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b1, 3'b000, mk(3'b000, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[2]  = '{1'b1, 3'b000, mk(3'b100, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[3]  = '{1'b1, 3'b001, mk(3'b000, 2'd1, 8'h11, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 3'b100, mk(3'b000, 2'd1, 8'h11, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 3'b010, mk(3'b010, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 3'b000, mk(3'b000, 2'd2, 8'h22, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[7]  = '{1'b0, 3'b010, mk(3'b000, 2'd2, 8'h22, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 3'b001, mk(3'b001, 2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)};
    tbl[9]  = '{1'b0, 3'b001, mk(3'b000, 2'd3, 8'h33, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 3'b000, mk(3'b000, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[11] = '{1'b0, 3'b000, mk(3'b000, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[12] = '{1'b1, 3'b000, mk(3'b000, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0)};
    tbl[13] = '{1'b0, 3'b000, mk(3'b100, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0)};

    // Reset state, checked while reset is held.
    #1;
    chk("reset_a", obs_a, '0);
    chk("reset_b", obs_b, '0);
    do_reset();

    // Table: mux isolation, stale/spurious dones, start held high, restart.
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      start = tbl[r].start;
      {init_done, ksa_done, prga_done} = tbl[r].dn;
      #1;
      chk($sformatf("tbl%0d_a", r), obs_a, tbl[r].exp);
      chk($sformatf("tbl%0d_b", r), obs_b, tbl[r].exp);
    end

    // Happy path on TIMEOUT=4096: each client answers N+1 cycles after its start.
    do_reset();
    c_i = -1; c_k = -1; c_p = -1; first_done = -1; seq_code = 0;
    np = '{0, 0, 0}; err_seen = 0; last_ph = 2'd0;
    for (int n = 0; n < 1500 && first_done < 0; n++) begin
      @(negedge clk);
      start     = (n == 0);
      init_done = (c_i >= 0) && (n == c_i + 261);
      ksa_done  = (c_k >= 0) && (n == c_k + 771);
      prga_done = (c_p >= 0) && (n == c_p + 101);
      #1;
      if (st_a[2]) begin np[0]++; c_i = n; end
      if (st_a[1]) begin np[1]++; c_k = n; end
      if (st_a[0]) begin np[2]++; c_p = n; end
      if (phase_a != last_ph) begin seq_code = seq_code * 4 + int'(phase_a); last_ph = phase_a; end
      if (error_a) err_seen = 1;
      if (done_a) first_done = n;
    end
    chk("happy_done_cycle", 64'(first_done), 64'd1137);
    chk("happy_init_pulses", 64'(np[0]), 64'd1);
    chk("happy_ksa_pulses", 64'(np[1]), 64'd1);
    chk("happy_prga_pulses", 64'(np[2]), 64'd1);
    chk("happy_phase_seq", 64'(seq_code), 64'd108);   // 1,2,3,0
    chk("happy_error", 64'(err_seen), 64'd0);
    chk("happy_busy_at_done", 64'(busy_a), 64'd0);
    init_done = 0; ksa_done = 0; prga_done = 0;

    // Watchdog on TIMEOUT=16: ksa_done withheld.
    do_reset();
    run_to_ksa_run();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (error_b) break;
      if (phase_b == 2'd2 && !st_b[1]) cnt++;
    end
    chk("wd_run_cycles", 64'(cnt), 64'd16);
    chk("wd_error", 64'(error_b), 64'd1);
    chk("wd_busy", 64'(busy_b), 64'd0);
    chk("wd_s_wren", 64'(wren_b), 64'd0);

    // Restart from FAULT.
    @(negedge clk); start = 1'b1; #1;
    chk("fault_hold_error", 64'(error_b), 64'd1);
    @(negedge clk); start = 1'b0; #1;
    chk("restart_init_start", 64'(st_b), 64'b100);
    chk("restart_error_clr", 64'(error_b), 64'd0);
    chk("restart_phase", 64'(phase_b), 64'd1);

    // Boundary: ksa_done in exactly the 16th KSA_RUN cycle.
    do_reset();
    run_to_ksa_run();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); ksa_done = (k == 16);
    end
    #1;
    chk("bound_last_run_phase", 64'(phase_b), 64'd2);
    @(negedge clk); ksa_done = 1'b0; #1;
    chk("bound_prga_start", 64'(st_b), 64'b001);
    chk("bound_no_error", 64'(error_b), 64'd0);

    // Asynchronous reset mid-KSA_RUN.
    do_reset();
    run_to_ksa_run();
    @(negedge clk); #1;
    chk("mid_ksa_s_addr", 64'(addr_b), 64'h22);
    chk("mid_ksa_s_wren", 64'(wren_b), 64'd1);
    #2 reset_n = 1'b0; start = 1'b1;
    #1;
    chk("async_rst_a", obs_a, '0);
    chk("async_rst_b", obs_b, '0);
    pulse_seen = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (st_a != 3'b000 || st_b != 3'b000) pulse_seen = 1;
    end
    chk("rst_no_pulses", 64'(pulse_seen), 64'd0);
    start = 1'b0; reset_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_idle_a", obs_a, '0);
    chk("post_rst_idle_b", obs_b, '0);

    // Random stimulus against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 5) == 0);
      init_done = ($urandom_range(0, 19) == 0);
      ksa_done  = ($urandom_range(0, 19) == 0);
      prga_done = ($urandom_range(0, 19) == 0);
      init_addr = 8'($urandom); ksa_addr = 8'($urandom); prga_addr = 8'($urandom);
      init_data = 8'($urandom); ksa_data = 8'($urandom); prga_data = 8'($urandom);
      init_wren = 1'($urandom); ksa_wren = 1'($urandom); prga_wren = 1'($urandom);
      #1;
      chk($sformatf("rand%0d_a", n), obs_a, exp_obs(0));
      chk($sformatf("rand%0d_b", n), obs_b, exp_obs(1));
      @(posedge clk);
      m_step(0);
      m_step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
